// File: rtl/stream_source.sv
// rtl/stream_source.sv - programmable burst traffic generator driving a valid/ready byte stream
module stream_source #(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned GAP_W     = 4,
  parameter logic [7:0]  LFSR_TAPS = 8'hB8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_length,
  input  logic [7:0]       cfg_seed,
  input  logic             cfg_mode,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             busy,
  output logic             done,
  input  logic             stream_out_ready,
  output logic             stream_out_valid,
  output logic [7:0]       stream_out_data,
  output logic [63:0]      stream_out_data_wide
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       data_q, data_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       next_data;
  logic             accept;

  assign accept = valid_q & stream_out_ready;

  always_comb begin
    if (mode_q) begin
      next_data = {1'b0, data_q[7:1]} ^ (data_q[0] ? LFSR_TAPS : 8'h00);
    end else begin
      next_data = data_q + 8'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    data_d    = data_q;
    idx_d     = idx_q;
    len_d     = len_q;
    mode_d    = mode_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_length != '0) begin
            state_d = ST_SEND;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            idx_d   = '0;
            len_d   = cfg_length;
            mode_d  = cfg_mode;
            gap_d   = cfg_gap;
            // An all-zero LFSR state would lock up, so it is nudged to 1
            data_d  = (cfg_mode && cfg_seed == 8'h00) ? 8'h01 : cfg_seed;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + LEN_W'(1);
            data_d = next_data;
            if (gap_q != '0) begin
              state_d   = ST_GAP;
              valid_d   = 1'b0;
              gap_cnt_d = gap_q;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= 8'h00;
      idx_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign stream_out_valid     = valid_q;
  assign stream_out_data      = data_q;
  assign stream_out_data_wide = {16'(idx_q), 40'h0, data_q};

endmodule
